// File: rtl/alarm_trigger.sv
// Alarm sequencer: compares time-of-day to the programmed alarm, then rings,
// snoozes, times out, and produces the musicClk beat for downstream light/sound.
module alarm_trigger #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int SNOOZE_SEC    = 300,
  parameter int RING_SEC      = 60,
  parameter int BEAT_HALF     = 12500000,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_enable,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       turnedOn,
  output logic       musicClk,
  output logic       snoozing,
  output logic       missed,
  output logic [1:0] dbg_state_o
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int BW = (BEAT_HALF > 1) ? $clog2(BEAT_HALF) : 1;
  localparam int CW = $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          match_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] snz_cnt_q, snz_cnt_d;
  logic          music_q, music_d;
  logic          missed_q, missed_d;
  logic          turned_on_q, snoozing_q;

  logic match, hit, tick_wrap, ring_to, snz_to, entering, enter_ring, staying;

  assign match = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
  assign hit   = match && !match_q;

  // Timeouts fire on the final prescaler wrap so the dwell is exactly N*TICKS_PER_SEC cycles.
  assign tick_wrap = (presc_q == PW'(TICKS_PER_SEC - 1));
  assign ring_to   = tick_wrap && (sec_q == SW'(RING_SEC - 1));
  assign snz_to    = tick_wrap && (sec_q == SW'(SNOOZE_SEC - 1));

  always_comb begin
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;
    missed_d  = missed_q;
    if (stop_btn) missed_d = 1'b0;
    if (!alarm_enable) begin
      state_d   = IDLE;
      snz_cnt_d = '0;
      missed_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: if (hit) begin
          state_d   = RINGING;
          snz_cnt_d = '0;
        end
        RINGING: begin
          if (stop_btn) begin
            state_d = ARMED;
          end else if (snooze_btn && (snz_cnt_q < CW'(MAX_SNOOZE))) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + CW'(1);
          end else if (ring_to) begin
            state_d  = ARMED;
            missed_d = 1'b1;
          end
        end
        SNOOZE: begin
          if (stop_btn)    state_d = ARMED;
          else if (snz_to) state_d = RINGING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign entering   = (state_d != state_q) && ((state_d == RINGING) || (state_d == SNOOZE));
  assign enter_ring = (state_d == RINGING) && (state_q != RINGING);
  assign staying    = (state_d == state_q) && ((state_q == RINGING) || (state_q == SNOOZE));

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    beat_d  = beat_q;
    music_d = music_q;
    if (entering) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (staying) begin
      if (tick_wrap) begin
        presc_d = '0;
        sec_d   = sec_q + SW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (enter_ring || (state_d != RINGING)) begin
      beat_d  = '0;
      music_d = 1'b0;
    end else if (beat_q == BW'(BEAT_HALF - 1)) begin
      beat_d  = '0;
      music_d = !music_q;
    end else begin
      beat_d = beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      match_q     <= 1'b0;
      presc_q     <= '0;
      sec_q       <= '0;
      beat_q      <= '0;
      snz_cnt_q   <= '0;
      music_q     <= 1'b0;
      missed_q    <= 1'b0;
      turned_on_q <= 1'b0;
      snoozing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      beat_q      <= beat_d;
      snz_cnt_q   <= snz_cnt_d;
      music_q     <= music_d;
      missed_q    <= missed_d;
      turned_on_q <= (state_d == RINGING);
      snoozing_q  <= (state_d == SNOOZE);
    end
  end

  assign turnedOn    = turned_on_q;
  assign musicClk    = music_q;
  assign snoozing    = snoozing_q;
  assign missed      = missed_q;
  assign dbg_state_o = state_q;

endmodule
